ex_operand_stage: RTL

- ID/EX pipeline stage that sits directly upstream of the 16-bit ALU. It captures decoded operands, opcode and imm from decode, and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's Data1/Data2/op/imm inputs from registered state.
- Holds the architectural flag register, which captures ALU flags when a flag-setting instruction completes EX.
- Supports a stall (hold) and a flush (bubble) from the hazard unit.

---
 rtl/ex_operand_stage_pkg.sv | 28 ++
 rtl/fwd_mux.sv | 40 ++++
 rtl/ex_operand_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg
//   Shared widths, flag bit positions and ALU opcode encodings for the
//   ID/EX operand stage and the 16-bit ALU it feeds.
package ex_operand_stage_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 4;
  localparam int OP_W    = 3;
  localparam int IMM_W   = 4;
  localparam int FLAG_W  = 3;

  // Flag register bit positions.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux
//   Combinational RAW-hazard forwarding select for one source operand.
//   Ports:
//     rs_i             source register index being read
//     rdata_i          value to use when no later stage is writing rs_i
//     exmem_wen_i/rd_i/result_i  EX/MEM writer (highest priority)
//     memwb_wen_i/rd_i/result_i  MEM/WB writer
//     fwd_o            resolved operand value
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = RADDR_W
) (
  input  logic [AW-1:0] rs_i,
  input  logic [DW-1:0] rdata_i,
  input  logic          exmem_wen_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_wen_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic [DW-1:0] fwd_o
);

  // r0 is hardwired zero, so a pending write to r0 must never be forwarded;
  // checking rs first covers both writers at once. EX/MEM holds the younger
  // result, so it wins over MEM/WB.
  always_comb begin
    fwd_o = rdata_i;
    if (rs_i == '0) begin
      fwd_o = '0;
    end else if (exmem_wen_i && (exmem_rd_i == rs_i)) begin
      fwd_o = exmem_result_i;
    end else if (memwb_wen_i && (memwb_rd_i == rs_i)) begin
      fwd_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register in front of the 16-bit ALU. Captures decoded
//   operands/opcode/imm, resolves RAW hazards by forwarding from EX/MEM and
//   MEM/WB, and owns the architectural flag register.
//   Ports:
//     clk, rst              clock; synchronous active-high reset
//     stall, flush          hazard-unit hold / bubble insert (flush wins)
//     id_*                  decode-slot instruction fields
//     exmem_*, memwb_*      downstream writers used for forwarding
//     alu_flag              combinational ALU flags for the instruction in EX
//     ex_*                  registered ALU inputs and pipeline control
//     flag_q                architectural flags {Z,V,N}
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [OP_W-1:0]    id_op,
  input  logic [IMM_W-1:0]   id_imm,
  input  logic               id_wen,
  input  logic               id_flag_en,
  input  logic               exmem_wen,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_wen,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  input  logic [FLAG_W-1:0]  alu_flag,
  output logic [DATA_W-1:0]  ex_data1,
  output logic [DATA_W-1:0]  ex_data2,
  output logic [OP_W-1:0]    ex_op,
  output logic [IMM_W-1:0]   ex_imm,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_valid,
  output logic               ex_wen,
  output logic               ex_flag_en,
  output logic [FLAG_W-1:0]  flag_q
);

  logic [DATA_W-1:0]  data1_q,   data1_d;
  logic [DATA_W-1:0]  data2_q,   data2_d;
  logic [OP_W-1:0]    op_q,      op_d;
  logic [IMM_W-1:0]   imm_q,     imm_d;
  logic [RADDR_W-1:0] rs1_q,     rs1_d;
  logic [RADDR_W-1:0] rs2_q,     rs2_d;
  logic [RADDR_W-1:0] rd_q,      rd_d;
  logic               valid_q,   valid_d;
  logic               wen_q,     wen_d;
  logic               flag_en_q, flag_en_d;
  logic [FLAG_W-1:0]  flag_r_q,  flag_r_d;

  logic [DATA_W-1:0]  id_fwd1, id_fwd2;
  logic [DATA_W-1:0]  hold_fwd1, hold_fwd2;

  // Operands entering from decode.
  fwd_mux #(.DW(DATA_W), .AW(RADDR_W)) u_fwd_id1 (
    .rs_i           (id_rs1),
    .rdata_i        (id_rdata1),
    .exmem_wen_i    (exmem_wen),
    .exmem_rd_i     (exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_wen_i    (memwb_wen),
    .memwb_rd_i     (memwb_rd),
    .memwb_result_i (memwb_result),
    .fwd_o          (id_fwd1)
  );

  fwd_mux #(.DW(DATA_W), .AW(RADDR_W)) u_fwd_id2 (
    .rs_i           (id_rs2),
    .rdata_i        (id_rdata2),
    .exmem_wen_i    (exmem_wen),
    .exmem_rd_i     (exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_wen_i    (memwb_wen),
    .memwb_rd_i     (memwb_rd),
    .memwb_result_i (memwb_result),
    .fwd_o          (id_fwd2)
  );

  // Held operands are re-forwarded every stalled cycle: a producer may
  // pass through EX/MEM or MEM/WB while we wait, and without this the
  // value captured before its write-back would go stale.
  fwd_mux #(.DW(DATA_W), .AW(RADDR_W)) u_fwd_hold1 (
    .rs_i           (rs1_q),
    .rdata_i        (data1_q),
    .exmem_wen_i    (exmem_wen),
    .exmem_rd_i     (exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_wen_i    (memwb_wen),
    .memwb_rd_i     (memwb_rd),
    .memwb_result_i (memwb_result),
    .fwd_o          (hold_fwd1)
  );

  fwd_mux #(.DW(DATA_W), .AW(RADDR_W)) u_fwd_hold2 (
    .rs_i           (rs2_q),
    .rdata_i        (data2_q),
    .exmem_wen_i    (exmem_wen),
    .exmem_rd_i     (exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_wen_i    (memwb_wen),
    .memwb_rd_i     (memwb_rd),
    .memwb_result_i (memwb_result),
    .fwd_o          (hold_fwd2)
  );

  always_comb begin
    data1_d   = data1_q;
    data2_d   = data2_q;
    op_d      = op_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    wen_d     = wen_q;
    flag_en_d = flag_en_q;

    if (flush) begin
      data1_d   = '0;
      data2_d   = '0;
      op_d      = '0;
      imm_d     = '0;
      rs1_d     = '0;
      rs2_d     = '0;
      rd_d      = '0;
      valid_d   = 1'b0;
      wen_d     = 1'b0;
      flag_en_d = 1'b0;
    end else if (stall) begin
      data1_d = hold_fwd1;
      data2_d = hold_fwd2;
    end else begin
      data1_d   = id_fwd1;
      data2_d   = id_fwd2;
      op_d      = id_op;
      imm_d     = id_imm;
      rs1_d     = id_rs1;
      rs2_d     = id_rs2;
      rd_d      = id_rd;
      valid_d   = id_valid;
      // A bubble must never write the register file or the flags.
      wen_d     = id_valid & id_wen;
      flag_en_d = id_valid & id_flag_en;
    end
  end

  // The instruction currently in EX completes on any non-stalled edge,
  // including a flush edge, so its flags are committed regardless of flush.
  always_comb begin
    flag_r_d = flag_r_q;
    if (!stall && valid_q && flag_en_q) begin
      flag_r_d = alu_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data1_q   <= '0;
      data2_q   <= '0;
      op_q      <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      wen_q     <= 1'b0;
      flag_en_q <= 1'b0;
      flag_r_q  <= '0;
    end else begin
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      wen_q     <= wen_d;
      flag_en_q <= flag_en_d;
      flag_r_q  <= flag_r_d;
    end
  end

  assign ex_data1   = data1_q;
  assign ex_data2   = data2_q;
  assign ex_op      = op_q;
  assign ex_imm     = imm_q;
  assign ex_rs1     = rs1_q;
  assign ex_rs2     = rs2_q;
  assign ex_rd      = rd_q;
  assign ex_valid   = valid_q;
  assign ex_wen     = wen_q;
  assign ex_flag_en = flag_en_q;
  assign flag_q     = flag_r_q;

endmodule
